ram_port_arbiter: RTL and testbench

- Shares the single-port program/data RAM between two requesters:
  - the CPU data port (load/store), and
  - a DMA/program-loader port used to preload code at PROG_START and to move buffers.
- Combinational grant, so a granted access costs zero added latency. Read data returns one cycle later.
- Bounded-hold round-robin arbitration, so neither side starves. Sits between the core and `ram`. The CPU stalls its pc update while `cpu_stall` is high.

---
 rtl/ram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Bounded-hold round-robin arbiter sharing one single-port RAM between the CPU and DMA ports.
// Optional feature macro: ARB_DMA_LOCK_EN (adds dma_lock for atomic DMA bursts).
module ram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
`ifdef ARB_DMA_LOCK_EN
  input  logic              dma_lock,
`endif
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic [3:0]        hold_cnt_reg, hold_cnt_next;
  logic              streak;
  logic              lock_hold;
  logic              cpu_gnt_c, dma_gnt_c;
  logic              any_gnt;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [DATA_W-1:0] last_wdata_reg;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rw;

  assign streak = (state_reg != IDLE);

`ifdef ARB_DMA_LOCK_EN
  // The lock only extends a run DMA already owns; it never steals ownership.
  assign lock_hold = dma_lock && (state_reg == DMA_OWN);
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b1;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    cpu_gnt_c     = 1'b0;
    dma_gnt_c     = 1'b0;
    state_next    = IDLE;
    owner_next    = owner_reg;
    hold_cnt_next = '0;
    if (cpu_req && dma_req) begin
      if (streak && ((hold_cnt_reg < MAX_HOLD_C) || lock_hold)) begin
        dma_gnt_c = owner_reg;
        cpu_gnt_c = ~owner_reg;
      end else begin
        dma_gnt_c = ~owner_reg;
        cpu_gnt_c = owner_reg;
      end
    end else begin
      cpu_gnt_c = cpu_req;
      dma_gnt_c = dma_req;
    end
    if (cpu_gnt_c || dma_gnt_c) begin
      owner_next = dma_gnt_c;
      state_next = dma_gnt_c ? DMA_OWN : CPU_OWN;
      if (streak && (owner_reg == dma_gnt_c))
        hold_cnt_next = (hold_cnt_reg >= MAX_HOLD_C) ? hold_cnt_reg : hold_cnt_reg + 4'd1;
      else
        hold_cnt_next = 4'd1;
    end
  end

  // Grants are masked while reset is low so nothing reaches the RAM mid-reset.
  assign cpu_gnt   = cpu_gnt_c & rst;
  assign dma_gnt   = dma_gnt_c & rst;
  assign any_gnt   = cpu_gnt | dma_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign sel_rw    = dma_gnt ? dma_rw    : cpu_rw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr_reg  <= '0;
      last_wdata_reg <= '0;
    end else if (any_gnt) begin
      last_addr_reg  <= sel_addr;
      last_wdata_reg <= sel_wdata;
    end
  end

  assign ram_addr  = any_gnt ? sel_addr  : last_addr_reg;
  assign ram_wdata = any_gnt ? sel_wdata : last_wdata_reg;
  assign ram_rw    = any_gnt & sel_rw;

  // Per-port read return: index 0 is the CPU, index 1 is the DMA.
  logic [1:0]        gnt_vec;
  logic [1:0]        rw_vec;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_vec [2];

  assign gnt_vec = {dma_gnt, cpu_gnt};
  assign rw_vec  = {dma_rw, cpu_rw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic rd_pend_reg;
    logic rd_pend_next;

    assign rd_pend_next = gnt_vec[gi] & ~rw_vec[gi];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_pend_reg <= 1'b0;
      else      rd_pend_reg <= rd_pend_next;
    end

    assign rvalid_vec[gi] = rd_pend_reg;
    assign rdata_vec[gi]  = rd_pend_reg ? ram_rdata : '0;
  end

  assign cpu_rvalid = rvalid_vec[0];
  assign dma_rvalid = rvalid_vec[1];
  assign cpu_rdata  = rdata_vec[0];
  assign dma_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: run-length arbitration model plus memory model, checked every cycle.
module tb_ram_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_rw;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_rw;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_lock;
  logic        dma_gnt, dma_rvalid;
  logic [15:0] dma_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_rw;

  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
`ifdef ARB_DMA_LOCK_EN
    .dma_lock(dma_lock),
`endif
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM the arbiter drives: registered read, write on ram_rw.
  logic [15:0] ram_mem   [0:65535];
  logic [15:0] model_mem [0:65535];

  always @(posedge clk) begin
    if (ram_rw) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who got the last grant, and how many consecutive cycles in a row (0 = idle cycle).
  logic        m_last;
  int          m_run;
  logic        m_pend_cpu, m_pend_dma;
  logic [15:0] m_cpu_data, m_dma_data;
  logic [15:0] m_last_addr, m_last_wdata;

  function automatic logic [1:0] exp_grant();
    logic w;
    if (cpu_req && dma_req) begin
      if (m_run > 0 && (m_run < MAX_HOLD || (dma_lock && m_last))) w = m_last;
      else w = !m_last;
      return w ? 2'b10 : 2'b01;
    end
    if (cpu_req) return 2'b01;
    if (dma_req) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic eg_cpu();
    logic [1:0] t;
    t = exp_grant();
    return t[0];
  endfunction

  function automatic logic eg_dma();
    logic [1:0] t;
    t = exp_grant();
    return t[1];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_last       <= 1'b1;
      m_run        <= 0;
      m_pend_cpu   <= 1'b0;
      m_pend_dma   <= 1'b0;
      m_last_addr  <= '0;
      m_last_wdata <= '0;
    end else begin
      m_pend_cpu <= eg_cpu() && !cpu_rw;
      m_cpu_data <= model_mem[cpu_addr];
      m_pend_dma <= eg_dma() && !dma_rw;
      m_dma_data <= model_mem[dma_addr];
      if (eg_cpu() || eg_dma()) begin
        m_run        <= (m_run > 0 && eg_dma() == m_last) ? m_run + 1 : 1;
        m_last       <= eg_dma();
        m_last_addr  <= eg_dma() ? dma_addr : cpu_addr;
        m_last_wdata <= eg_dma() ? dma_wdata : cpu_wdata;
        if (eg_dma() && dma_rw) model_mem[dma_addr] <= dma_wdata;
        if (eg_cpu() && cpu_rw) model_mem[cpu_addr] <= cpu_wdata;
      end else begin
        m_run <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("rst_ram_rw", 32'(ram_rw), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    end else begin
      chk("cyc_cpu_gnt", 32'(cpu_gnt), 32'(eg_cpu()));
      chk("cyc_dma_gnt", 32'(dma_gnt), 32'(eg_dma()));
      chk("cyc_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_cpu()));
      chk("cyc_ram_rw", 32'(ram_rw), 32'((eg_cpu() && cpu_rw) || (eg_dma() && dma_rw)));
      chk("cyc_ram_addr", 32'(ram_addr),
          32'(eg_dma() ? dma_addr : (eg_cpu() ? cpu_addr : m_last_addr)));
      chk("cyc_ram_wdata", 32'(ram_wdata),
          32'(eg_dma() ? dma_wdata : (eg_cpu() ? cpu_wdata : m_last_wdata)));
      chk("cyc_cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend_cpu));
      chk("cyc_dma_rvalid", 32'(dma_rvalid), 32'(m_pend_dma));
      chk("cyc_cpu_rdata", 32'(cpu_rdata), 32'(m_pend_cpu ? m_cpu_data : 16'h0));
      chk("cyc_dma_rdata", 32'(dma_rdata), 32'(m_pend_dma ? m_dma_data : 16'h0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [15:0] pat;
  int          nd, ns;
  logic        cg, dg;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i]   = 16'h0;
      model_mem[i] = 16'h0;
    end
    ram_mem[16'h000F]   = 16'h1234;
    model_mem[16'h000F] = 16'h1234;
    rst = 1'b0; dma_lock = 1'b0;
    dma_req = 1'b0; dma_rw = 1'b0; dma_addr = '0; dma_wdata = '0;
    // A write request during reset must not reach the RAM.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hDEAD;
    #3;
    chk("reset_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("reset_ram_rw", 32'(ram_rw), 32'd0);
    cpu_req = 1'b0; cpu_rw = 1'b0;
    step; step;
    rst = 1'b1;

    // Solo CPU read
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h000F;
    #3;
    chk("solo_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("solo_dma_gnt", 32'(dma_gnt), 32'd0);
    step;
    cpu_req = 1'b0;
    #3;
    chk("solo_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("solo_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    chk("solo_dma_gnt_after", 32'(dma_gnt), 32'd0);
    step;

    // Tie right after reset: runs of four
    rst = 1'b0;
    step;
    rst = 1'b1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_rw = 1'b0; dma_rw = 1'b0;
    cpu_addr = 16'h0010; dma_addr = 16'h0011;
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      #3;
      pat[i] = cpu_gnt;
      step;
    end
    chk("tie_pattern", 32'(pat), 32'h0F0F);

    // Idle cycle breaks the CPU streak
    dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("streak_cpu_gnt", 32'(cpu_gnt), 32'd1);
      step;
    end
    cpu_req = 1'b0;
    step;
    cpu_req = 1'b1; dma_req = 1'b1;
    #3;
    chk("idle_break_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("idle_break_cpu_stall", 32'(cpu_stall), 32'd1);
    step;
    cpu_req = 1'b0; dma_req = 1'b0;
    step;

    // DMA write then CPU read of the same word
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h0020; dma_wdata = 16'hBEEF;
    #3;
    chk("wr_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("wr_ram_rw", 32'(ram_rw), 32'd1);
    step;
    dma_req = 1'b0; dma_rw = 1'b0;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0020;
    #3;
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_ram_rw", 32'(ram_rw), 32'd0);
    step;
    cpu_req = 1'b0;
    #3;
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
    step;

    // Reset falls while a CPU read is in flight
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h000F;
    #3;
    chk("mid_cpu_gnt", 32'(cpu_gnt), 32'd1);
    #4;
    rst = 1'b0;
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h0030; dma_wdata = 16'h0001;
    #1;
    chk("mid_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("mid_rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("mid_rst_ram_rw", 32'(ram_rw), 32'd0);
    chk("mid_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    step;
    #2;
    chk("mid_rst_no_rvalid", 32'(cpu_rvalid), 32'd0);
    step;
    rst = 1'b1;
    #3;
    chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("post_rst_dma_gnt", 32'(dma_gnt), 32'd0);
    step;
    cpu_req = 1'b0; dma_req = 1'b0; dma_rw = 1'b0;
    step;

`ifdef ARB_DMA_LOCK_EN
    // DMA takes ownership, then holds it under lock for ten contested cycles
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0011;
    #3;
    chk("lock_dma_own", 32'(dma_gnt), 32'd1);
    step;
    dma_lock = 1'b1;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0010;
    nd = 0; ns = 0;
    for (int i = 0; i < 10; i++) begin
      #3;
      nd += int'(dma_gnt);
      ns += int'(cpu_stall);
      step;
    end
    chk("lock_dma_gnts", 32'(nd), 32'd10);
    chk("lock_cpu_stalls", 32'(ns), 32'd10);
    dma_lock = 1'b0;
    #3;
    chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step;
    cpu_req = 1'b0; dma_req = 1'b0;
    step;
`endif

    // Mixed traffic over a small address window; requests held until granted
    cg = 1'b0; dg = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!cpu_req || cg) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_rw    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'h0040 + 16'($urandom_range(0, 7));
        cpu_wdata = 16'($urandom);
      end
      if (!dma_req || dg) begin
        dma_req   = ($urandom_range(0, 3) != 0);
        dma_rw    = 1'($urandom_range(0, 1));
        dma_addr  = 16'h0040 + 16'($urandom_range(0, 7));
        dma_wdata = 16'($urandom);
      end
      #3;
      cg = cpu_gnt;
      dg = dma_gnt;
      step;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step; step;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
